ps2_rx_ctrl: RTL
================

// Module: ps2_rx_ctrl
// PURPOSE
//   Receive-side controller for the PS/2 keyboard port. Synchronises and deglitches
//   PS2_CLK/PS2_DAT into the CLOCK_50 domain, sequences the 11-bit frame (start, 8 data
//   LSB-first, odd parity, stop) through a state machine, and checks parity and framing.
//   Delivers each good byte on a valid/ready interface. Replaces direct sampling of the
//   pins by a free-running shift register; sits between the PS/2 pins and the
//   scancode/display logic.
// PARAMETERS
//   FILTER_LEN      8       consecutive equal samples needed to accept a new PS2_CLK/PS2_DAT level
//   TIMEOUT_CYCLES  100000  CLOCK_50 cycles without a PS2_CLK falling edge that abort a frame (2 ms)
// PORTS
//   CLOCK_50     in   1  system clock, 50 MHz
//   RESET_N      in   1  asynchronous reset, active-low
//   PS2_CLK      in   1  PS/2 clock pin (receive only; top level leaves the inout released)
//   PS2_DAT      in   1  PS/2 data pin
//   rx_data      out  8  received byte, stable while rx_valid=1
//   rx_valid     out  1  byte available; held until accepted
//   rx_ready     in   1  consumer accepts byte when rx_valid&rx_ready at a rising edge
//   parity_err   out  1  one-cycle pulse: frame parity not odd
//   framing_err  out  1  one-cycle pulse: start bit=1, stop bit=0, or timeout
//   overrun      out  1  sticky: good frame completed while rx_valid=1; cleared on accept
//   busy         out  1  1 while state != IDLE
// BEHAVIOUR
//   Reset: all outputs 0, rx_data=8'h00, state=IDLE, bit counter=0, sync/filter regs=1 (idle bus).
//   Input path: 2-FF synchroniser, then FILTER_LEN-sample filter per line. fall = filtered
//     PS2_CLK 1->0, asserted for one cycle. Pin edge to fall = 2+FILTER_LEN cycles (max).
//   All sampling of filtered PS2_DAT happens in the cycle fall=1.
//   FSM:
//     IDLE   -fall & dat=0-> DATA (cnt=0); fall & dat=1 -> framing_err pulse, stay IDLE
//     DATA   -fall-> shift dat into sr[7] (sr>>1), cnt++; cnt==7 on fall -> PARITY
//     PARITY -fall-> store par bit -> STOP
//     STOP   -fall-> evaluate: dat=0 -> framing_err; else ^{sr,par}==0 -> parity_err;
//            else good byte. Always -> IDLE.
//   Good byte: if rx_valid=0 or (rx_valid&rx_ready) in the same cycle -> rx_data<=sr, rx_valid<=1
//     next cycle. If rx_valid=1 and rx_ready=0 -> byte dropped, overrun<=1, old rx_data kept.
//   Accept (rx_valid&rx_ready, no new byte) -> rx_valid<=0, overrun<=0.
//   Error pulses never coincide with a valid-set; errored frames never reach rx_data.
//   RESET_N low mid-frame: immediate return to IDLE, partial byte discarded.
//   Frames start only on a falling edge with dat=0; a frame in progress is never restarted
//     except by timeout or reset.
// CONFIGURATION
//   PS2_RX_TIMEOUT_EN defined: a counter clears on every fall and while IDLE, increments
//     otherwise; reaching TIMEOUT_CYCLES-1 outside IDLE -> framing_err pulse, state<=IDLE,
//     cnt<=0.
//   Not defined: no timeout counter; a truncated frame waits indefinitely for further edges
//     (recovery by reset only).
// STRUCTURE
//   Shared include ps2_defs.vh: state encodings (ST_IDLE/ST_DATA/ST_PARITY/ST_STOP),
//     FRAME_DATA_BITS=8, PS2_IDLE_LEVEL=1.
//   Sub-module ps2_sync_filter (one instance per line): synchroniser + FILTER_LEN filter,
//     output level plus fall strobe.
// TESTING (bus model: 12.5 kHz PS2_CLK, data changes mid-high)
//   1 frame 0x1C, par=0, stop=1 -> rx_valid=1, rx_data=8'h1C, no error pulses; rx_ready=1 -> rx_valid=0
//   2 frame 0xF0 with par=0 (wrong) -> one parity_err pulse, rx_valid stays 0
//   3 frame 0x1C with stop=0 -> one framing_err pulse; next good 0x32 frame -> rx_data=8'h32
//   4 frames 0x1C then 0x32, rx_ready=0 -> rx_data=8'h1C, overrun=1; rx_ready=1 -> rx_valid=0, overrun=0
//   5 (PS2_RX_TIMEOUT_EN) stop clock after 4 data bits -> framing_err at TIMEOUT_CYCLES, busy=0;
//     then 0xE0 received correctly
//   6 RESET_N low mid-frame for 3 cycles -> all outputs 0; following 0x5A frame -> rx_data=8'h5A

Source files
------------

// File: rtl/ps2_rx_ctrl_pkg.sv
// Shared definitions for the PS/2 receive path: FSM state encodings,
// frame geometry, idle bus level and the frame parity helper.
package ps2_rx_ctrl_pkg;

    // Receive sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam int   FRAME_DATA_BITS = 8;
    localparam logic PS2_IDLE_LEVEL  = 1'b1;

    // PS/2 uses odd parity over data + parity bit: 1 means the frame is good
    function automatic logic parity_odd(input logic [FRAME_DATA_BITS-1:0] data,
                                        input logic                       par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Single-line input conditioner: 2-FF synchroniser followed by a
// FILTER_LEN-sample level filter. The filtered level only changes after
// FILTER_LEN consecutive equal samples; fall pulses for one cycle in the
// first cycle the filtered level reads 0 after having been 1.
module ps2_sync_filter
    import ps2_rx_ctrl_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic fall
);

    logic [1:0]            sync_q;
    logic [1:0]            sync_d;
    logic [FILTER_LEN-1:0] hist_q;
    logic [FILTER_LEN-1:0] hist_d;
    logic                  level_q;
    logic                  level_d;
    logic                  fall_q;
    logic                  fall_d;

    // Shift the synchronised sample into the history; flip the level on a full run
    always_comb begin
        sync_d  = {sync_q[0], din};
        hist_d  = {hist_q[FILTER_LEN-2:0], sync_q[1]};
        level_d = level_q;
        if (&hist_d) begin
            level_d = 1'b1;
        end else if (~|hist_d) begin
            level_d = 1'b0;
        end
        fall_d  = level_q & ~level_d;
    end

    // Registers reset to the idle (released) bus level so no false edge follows reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {2{PS2_IDLE_LEVEL}};
            hist_q  <= {FILTER_LEN{PS2_IDLE_LEVEL}};
            level_q <= PS2_IDLE_LEVEL;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            level_q <= level_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: conditions PS2_CLK/PS2_DAT, sequences the
// 11-bit frame (start, 8 data LSB first, odd parity, stop), checks parity
// and framing and hands good bytes out on a valid/ready interface.
// Optional frame timeout enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_ctrl
    import ps2_rx_ctrl_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET_N,
    input  logic                       PS2_CLK,
    input  logic                       PS2_DAT,
    output logic [FRAME_DATA_BITS-1:0] rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic                       parity_err,
    output logic                       framing_err,
    output logic                       overrun,
    output logic                       busy
);

    localparam int CNT_W = $clog2(FRAME_DATA_BITS);

    logic clk_fall;
    logic dat_lvl;
    logic clk_lvl_unused;
    logic dat_fall_unused;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .din   (PS2_CLK),
        .level (clk_lvl_unused),
        .fall  (clk_fall)
    );

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .din   (PS2_DAT),
        .level (dat_lvl),
        .fall  (dat_fall_unused)
    );

    ps2_state_e                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [FRAME_DATA_BITS-1:0] sr_q, sr_d;
    logic                       par_q, par_d;
    logic [FRAME_DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                       rx_valid_q, rx_valid_d;
    logic                       perr_q, perr_d;
    logic                       ferr_q, ferr_d;
    logic                       ovr_q, ovr_d;

    logic frame_good;
    logic tmo_hit;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Idle-time counter: cleared by every clock edge and while idle
    always_comb begin
        tmo_d   = tmo_q + 1'b1;
        if (clk_fall || state_q == ST_IDLE) begin
            tmo_d = '0;
        end
        tmo_hit = (state_q != ST_IDLE) && !clk_fall &&
                  (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    end

    // Timeout counter register
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    // Without the timeout a truncated frame waits for more edges or reset
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
    assign tmo_hit        = 1'b0;
`endif

    // Frame sequencer: next state, bit capture and per-frame verdict
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        par_d      = par_q;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        frame_good = 1'b0;
        if (clk_fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!dat_lvl) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
                ST_DATA: begin
                    sr_d  = {dat_lvl, sr_q[FRAME_DATA_BITS-1:1]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(FRAME_DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = dat_lvl;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (!dat_lvl) begin
                        ferr_d = 1'b1;
                    end else if (!parity_odd(sr_q, par_q)) begin
                        perr_d = 1'b1;
                    end else begin
                        frame_good = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (tmo_hit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ferr_d  = 1'b1;
        end
    end

    // Output handshake: load good bytes, flag drops while a byte is pending
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        ovr_d      = ovr_q;
        if (frame_good) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = sr_q;
                rx_valid_d = 1'b1;
                ovr_d      = 1'b0;
            end else begin
                ovr_d      = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
            ovr_d      = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            par_q      <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            par_q      <= par_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = perr_q;
    assign framing_err = ferr_q;
    assign overrun     = ovr_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
